// File: rtl/matrix_stream_host_pkg.sv
// Shared types and helpers for the matrix multiplier host link; reused by the multiplier bench.
package matrix_stream_host_pkg;

  localparam int unsigned word_width = 32;

  typedef enum logic [2:0] {
    StLoadA,
    StLoadB,
    StReq,
    StWaitC,
    StSend
  } host_state_e;

  // Bit offset of element (row, col) in a flat row-major matrix bus with 'cols' columns.
  function automatic int unsigned elem_offset(input int unsigned row, input int unsigned col,
                                              input int unsigned cols);
    return (row * cols + col) * word_width;
  endfunction

endpackage

// File: rtl/matrix_word_unpacker.sv
// Selects one word of a flat row-major matrix buffer; pure mux, out-of-range index yields zero.
module matrix_word_unpacker
  import matrix_stream_host_pkg::*;
#(
  parameter int unsigned elems     = 16,
  parameter int unsigned idx_width = 5
) (
  input  logic [elems*word_width-1:0] data,
  input  logic [idx_width-1:0]        idx,
  output logic [word_width-1:0]       word
);

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < elems; i++) begin
      if (idx == idx_width'(i)) begin
        word = data[elem_offset(0, i, elems) +: word_width];
      end
    end
  end

endmodule

// File: rtl/matrix_stream_host.sv
// Word-serial host initiator for the matrix multiplier stb/ack interface.
// Build option: MATRIX_STREAM_B_COLMAJOR_EN makes B arrive column-major on the input stream.
module matrix_stream_host
  import matrix_stream_host_pkg::*;
#(
  parameter int unsigned m = 4,
  parameter int unsigned p = 4,
  parameter int unsigned n = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [word_width-1:0]     in_data,
  input  logic                      in_stb,
  output logic                      in_ack,
  output logic [word_width-1:0]     out_data,
  output logic                      out_stb,
  input  logic                      out_ack,
  output logic [m*p*word_width-1:0] matrix_A,
  output logic [p*n*word_width-1:0] matrix_B,
  output logic                      a_stb,
  output logic                      b_stb,
  input  logic                      a_ack,
  input  logic                      b_ack,
  input  logic [m*n*word_width-1:0] matrix_C,
  input  logic                      c_stb,
  output logic                      c_ack,
  output logic                      busy
);

  localparam int unsigned MaxAB    = (m * p > p * n) ? m * p : p * n;
  localparam int unsigned MaxElems = (MaxAB > m * n) ? MaxAB : m * n;
  localparam int unsigned IdxWidth = $clog2(MaxElems) + 1;

  host_state_e                 state;
  logic [IdxWidth-1:0]         idx;
  logic [m*n*word_width-1:0]   c_buf;
  logic                        a_seen;
  logic                        b_seen;
  logic [word_width-1:0]       next_word;

`ifdef MATRIX_STREAM_B_COLMAJOR_EN
  logic [IdxWidth-1:0]         b_row;
  logic [IdxWidth-1:0]         b_col;
`endif

  // Word following the current one, so SEND can advance without a bubble.
  matrix_word_unpacker #(
    .elems    (m * n),
    .idx_width(IdxWidth)
  ) u_unpacker (
    .data(c_buf),
    .idx (idx + IdxWidth'(1)),
    .word(next_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StLoadA;
      idx      <= '0;
      c_buf    <= '0;
      matrix_A <= '0;
      matrix_B <= '0;
      a_seen   <= 1'b0;
      b_seen   <= 1'b0;
      in_ack   <= 1'b1;
      out_stb  <= 1'b0;
      out_data <= '0;
      a_stb    <= 1'b0;
      b_stb    <= 1'b0;
      c_ack    <= 1'b0;
      busy     <= 1'b0;
`ifdef MATRIX_STREAM_B_COLMAJOR_EN
      b_row    <= '0;
      b_col    <= '0;
`endif
    end else begin
      c_ack <= 1'b0;
      unique case (state)
        StLoadA: begin
          if (in_stb && in_ack) begin
            matrix_A[elem_offset(0, 32'(idx), p) +: word_width] <= in_data;
            busy <= 1'b1;
            if (idx == IdxWidth'(m * p - 1)) begin
              idx   <= '0;
              state <= StLoadB;
            end else begin
              idx <= idx + IdxWidth'(1);
            end
          end
        end

        StLoadB: begin
          if (in_stb && in_ack) begin
`ifdef MATRIX_STREAM_B_COLMAJOR_EN
            matrix_B[elem_offset(32'(b_row), 32'(b_col), n) +: word_width] <= in_data;
            if (b_row == IdxWidth'(p - 1)) begin
              b_row <= '0;
              b_col <= b_col + IdxWidth'(1);
            end else begin
              b_row <= b_row + IdxWidth'(1);
            end
`else
            matrix_B[elem_offset(0, 32'(idx), n) +: word_width] <= in_data;
`endif
            if (idx == IdxWidth'(p * n - 1)) begin
              idx    <= '0;
              in_ack <= 1'b0;
              a_stb  <= 1'b1;
              b_stb  <= 1'b1;
              state  <= StReq;
`ifdef MATRIX_STREAM_B_COLMAJOR_EN
              b_row  <= '0;
              b_col  <= '0;
`endif
            end else begin
              idx <= idx + IdxWidth'(1);
            end
          end
        end

        StReq: begin
          // Acks may land in different cycles; each is remembered until both are in.
          if (a_stb && a_ack) begin
            a_stb  <= 1'b0;
            a_seen <= 1'b1;
          end
          if (b_stb && b_ack) begin
            b_stb  <= 1'b0;
            b_seen <= 1'b1;
          end
          if (a_seen && b_seen) begin
            a_seen <= 1'b0;
            b_seen <= 1'b0;
            state  <= StWaitC;
          end
        end

        StWaitC: begin
          if (c_stb) begin
            c_buf    <= matrix_C;
            c_ack    <= 1'b1;
            out_data <= matrix_C[word_width-1:0];
            out_stb  <= 1'b1;
            idx      <= '0;
            state    <= StSend;
          end
        end

        StSend: begin
          if (out_stb && out_ack) begin
            if (idx == IdxWidth'(m * n - 1)) begin
              idx     <= '0;
              out_stb <= 1'b0;
              in_ack  <= 1'b1;
              busy    <= 1'b0;
              state   <= StLoadA;
            end else begin
              idx      <= idx + IdxWidth'(1);
              out_data <= next_word;
            end
          end
        end

        default: state <= StLoadA;
      endcase
    end
  end

endmodule
